ctrl_fsm: RTL and testbench
===========================

Name: ctrl_fsm

Overview:
- Multicycle ARM control unit: main FSM plus ALU and PC-select decode.
- Produces the raw enables NextPC, RegW, MemW, PCS and FlagW consumed by the conditional-execution logic. That logic gates them with CondEx and delays FlagW by one cycle.
- Also drives the datapath mux selects and IRWrite.
- Sits between the instruction register fields and condlogic inside the controller.

Parameters:
- None. Encodings are fixed.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; FSM to FETCH.
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S/L.
- Rd  in  4  Instr[15:12].
- IRWrite  out  1  instruction register load.
- AdrSrc  out  1  0=PC, 1=ALUResult (memory address).
- ALUSrcA  out  2  00=RD1, 01=PC, others unused.
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=const 4.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ImmSrc  out  2  equals Op.
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01).
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- FlagW  out  2  [1]=NZ write, [0]=CV write.
- PCS  out  1  PC-source request.
- NextPC  out  1  unconditional PC write.
- RegW  out  1  raw register write.
- MemW  out  1  raw memory write.

Behaviour:
- Moore FSM with one-hot or binary state. State register updates on rising clk; reset has priority over the next-state logic.
- FSM outputs are combinational from state only. Decode outputs are combinational from state and the Op/Funct/Rd fields.
- Any output not listed for a state is 0.
- States and per-state outputs:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1.
  - UNKNOWN: all outputs 0.
- Transitions:
  - FETCH->DECODE.
  - DECODE: Op=00 and Funct[5]=1 -> EXECUTEI; Op=00 and Funct[5]=0 -> EXECUTER; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> UNKNOWN.
  - MEMADR: Funct[0]=1 -> MEMRD, else MEMWR.
  - MEMRD->MEMWB->FETCH; MEMWR->FETCH.
  - EXECUTER/EXECUTEI->ALUWB->FETCH.
  - BRANCH->FETCH; UNKNOWN->FETCH.
- Cycle counts: data-processing 4, LDR 5, STR 4, B 3, undefined 3.
- ALU decode (ALUOp is internal):
  - ALUOp=0: ALUControl=00, FlagW=00.
  - ALUOp=1, decoded by Funct[4:1]: 0100 ADD->00, 0010 SUB->01, 0000 AND->10, 1100 ORR->11.
  - Unsupported cmd: ALUControl=00, FlagW=00.
  - FlagW[1]=Funct[0] for supported cmds. FlagW[0]=Funct[0]&(ADD|SUB).
- FlagW is nonzero only in EXECUTER/EXECUTEI. Downstream registers it into ALUWB.
- PCS=((Rd==1111)&RegW)|Branch, evaluated per cycle. It is therefore high in ALUWB/MEMWB when Rd=15, and in BRANCH.
- Reset behaviour:
  - Values during reset/after reset: FETCH outputs, i.e. IRWrite=1, NextPC=1, all others per FETCH.
  - Reset asserted mid-instruction: state is FETCH at the next edge regardless of current state; no RegW/MemW pulse is produced after that edge.
- Op/Funct/Rd are stable from DECODE until the next FETCH. The FSM samples them in DECODE and MEMADR only.

Test Plan:
- Reset high 2 cycles, release -> FETCH outputs (IRWrite=1, NextPC=1, ALUSrcB=10) then DECODE on next edge.
- ADDS R1,R2,R3 (Op=00, Funct=001001, Rd=0001) -> FETCH, DECODE, EXECUTER with ALUControl=00 FlagW=11, ALUWB with RegW=1 PCS=0, back to FETCH; 4 cycles.
- ORR immediate, no S, Rd=15 (Funct=111000) -> EXECUTEI with ALUControl=11 FlagW=00; ALUWB with RegW=1, PCS=1.
- LDR (Op=01, Funct[0]=1) -> MEMADR, MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegW=1); STR (Funct[0]=0) -> MEMWR MemW=1 for exactly 1 cycle.
- B (Op=10) -> BRANCH with Branch/PCS=1, ALUSrcB=01, then FETCH; Op=11 -> UNKNOWN with all outputs 0, then FETCH.
- Reset asserted during MEMWR -> MemW drops after that edge, FETCH entered; SUBS -> FlagW=11; ANDS -> FlagW=10.

Source files
------------

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multicycle ARM main FSM with ALU and PC-select decode
module ctrl_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN
  } state_t;
  state_t state, next;
  logic alu_op, branch;
  logic [3:0] cmd;
  logic is_add, is_sub, supported;
  always_ff @(posedge clk)
    state <= reset ? FETCH : next;
  always_comb begin
    next      = FETCH;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    alu_op    = 1'b0;
    branch    = 1'b0;
    case (state)
      FETCH: begin
        next      = DECODE;
        IRWrite   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        NextPC    = 1'b1;
      end
      DECODE: begin
        next      = Op == 2'b00 ? (Funct[5] ? EXECUTEI : EXECUTER) :
                    Op == 2'b01 ? MEMADR : Op == 2'b10 ? BRANCH : UNKNOWN;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        next    = Funct[0] ? MEMRD : MEMWR;
        ALUSrcB = 2'b01;
      end
      MEMRD: begin
        next   = MEMWB;
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: begin
        next   = ALUWB;
        alu_op = 1'b1;
      end
      EXECUTEI: begin
        next    = ALUWB;
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      ALUWB: RegW = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: next = FETCH;
    endcase
  end
  assign cmd        = Funct[4:1];
  assign is_add     = cmd == 4'b0100;
  assign is_sub     = cmd == 4'b0010;
  assign supported  = is_add | is_sub | cmd == 4'b0000 | cmd == 4'b1100;
  assign ALUControl = !alu_op ? 2'b00 : is_sub ? 2'b01 :
                      cmd == 4'b0000 ? 2'b10 : cmd == 4'b1100 ? 2'b11 : 2'b00;
  assign FlagW      = (alu_op & supported) ? {Funct[0], Funct[0] & (is_add | is_sub)} : 2'b00;
  assign PCS        = ((Rd == 4'hF) & RegW) | branch;
  // The undefined-instruction state forces every output low, including ImmSrc
  assign ImmSrc     = state == UNKNOWN ? 2'b00 : Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};
endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: directed per-instruction checks of ctrl_fsm state sequences and outputs
module tb_ctrl_fsm;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b0;
  logic [3:0] Rd = 4'b0;
  logic IRWrite, AdrSrc, PCS, NextPC, RegW, MemW;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW;
  logic [15:0] obs;
  int checks = 0, errors = 0;
  // obs = IRWrite AdrSrc ALUSrcA ALUSrcB ResultSrc ALUControl FlagW PCS NextPC RegW MemW
  localparam logic [15:0] F_O   = 16'b1_0_01_10_10_00_00_0_1_0_0;
  localparam logic [15:0] D_O   = 16'b0_0_01_10_10_00_00_0_0_0_0;
  localparam logic [15:0] MA_O  = 16'b0_0_00_01_00_00_00_0_0_0_0;
  localparam logic [15:0] MR_O  = 16'b0_1_00_00_00_00_00_0_0_0_0;
  localparam logic [15:0] MWR_O = 16'b0_1_00_00_00_00_00_0_0_0_1;
  localparam logic [15:0] WB_O  = 16'b0_0_00_00_00_00_00_0_0_1_0;
  localparam logic [15:0] BR_O  = 16'b0_0_00_01_10_00_00_1_0_0_0;

  ctrl_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW)
  );

  always #5 clk = ~clk;
  assign obs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW, PCS, NextPC, RegW, MemW};

  task automatic test_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== F_O) begin errors++; $display("FAIL reset_fetch got %b want %b", obs, F_O); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== D_O) begin errors++; $display("FAIL reset_decode got %b want %b", obs, D_O); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== F_O) begin errors++; $display("FAIL reset_from_decode got %b want %b", obs, F_O); end
    reset = 1'b0;
  endtask

  task automatic test_adds();
    logic [15:0] e [5] = '{F_O, D_O, 16'b0_0_00_00_00_00_11_0_0_0_0, WB_O, F_O};
    Op = 2'b00; Funct = 6'b001001; Rd = 4'd1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs !== e[i]) begin errors++; $display("FAIL adds[%0d] got %b want %b", i, obs, e[i]); end
    end
  endtask

  task automatic test_orr_imm_pc();
    logic [15:0] e [5] = '{F_O, D_O, 16'b0_0_00_01_00_11_00_0_0_0_0, 16'b0_0_00_00_00_00_00_1_0_1_0, F_O};
    Op = 2'b00; Funct = 6'b111000; Rd = 4'hF;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs !== e[i]) begin errors++; $display("FAIL orr_imm[%0d] got %b want %b", i, obs, e[i]); end
    end
  endtask

  task automatic test_ldr();
    logic [15:0] e [6] = '{F_O, D_O, MA_O, MR_O, 16'b0_0_00_00_01_00_00_1_0_1_0, F_O};
    Op = 2'b01; Funct = 6'b011001; Rd = 4'hF;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs !== e[i]) begin errors++; $display("FAIL ldr[%0d] got %b want %b", i, obs, e[i]); end
      if (i == 1) begin
        checks++;
        if ({ImmSrc, RegSrc} !== 4'b01_10) begin errors++; $display("FAIL ldr_imm_reg_src got %b want 0110", {ImmSrc, RegSrc}); end
      end
    end
  endtask

  task automatic test_str();
    logic [15:0] e [5] = '{F_O, D_O, MA_O, MWR_O, F_O};
    Op = 2'b01; Funct = 6'b011000; Rd = 4'hF;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs !== e[i]) begin errors++; $display("FAIL str[%0d] got %b want %b", i, obs, e[i]); end
    end
  endtask

  task automatic test_branch();
    logic [15:0] e [4] = '{F_O, D_O, BR_O, F_O};
    Op = 2'b10; Funct = 6'b100000; Rd = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs !== e[i]) begin errors++; $display("FAIL branch[%0d] got %b want %b", i, obs, e[i]); end
      if (i == 1) begin
        checks++;
        if ({ImmSrc, RegSrc} !== 4'b10_01) begin errors++; $display("FAIL branch_imm_reg_src got %b want 1001", {ImmSrc, RegSrc}); end
      end
    end
  endtask

  task automatic test_undef();
    logic [15:0] e [4] = '{F_O, D_O, 16'h0000, F_O};
    Op = 2'b11; Funct = 6'b001001; Rd = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs !== e[i]) begin errors++; $display("FAIL undef[%0d] got %b want %b", i, obs, e[i]); end
    end
  endtask

  task automatic test_alu_flags();
    logic [5:0] f [3] = '{6'b000101, 6'b000001, 6'b000011};
    logic [15:0] ex [3] = '{16'b0_0_00_00_00_01_11_0_0_0_0, 16'b0_0_00_00_00_10_10_0_0_0_0, 16'h0000};
    for (int k = 0; k < 3; k++) begin
      Op = 2'b00; Funct = f[k]; Rd = 4'd3;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (obs !== ex[k]) begin errors++; $display("FAIL alu_exec[%0d] got %b want %b", k, obs, ex[k]); end
      @(negedge clk);
      checks++;
      if (obs !== WB_O) begin errors++; $display("FAIL alu_wb[%0d] got %b want %b", k, obs, WB_O); end
      @(negedge clk);
      checks++;
      if (obs !== F_O) begin errors++; $display("FAIL alu_fetch[%0d] got %b want %b", k, obs, F_O); end
    end
  endtask

  task automatic test_reset_mid();
    Op = 2'b01; Funct = 6'b000000; Rd = 4'd4;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== MWR_O) begin errors++; $display("FAIL mid_memwr got %b want %b", obs, MWR_O); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== F_O) begin errors++; $display("FAIL mid_reset_fetch got %b want %b", obs, F_O); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== D_O) begin errors++; $display("FAIL mid_after_decode got %b want %b", obs, D_O); end
  endtask

  initial begin
    test_reset();
    test_adds();
    test_orr_imm_pc();
    test_ldr();
    test_str();
    test_branch();
    test_undef();
    test_alu_flags();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
